mem_stage: RTL and testbench

Memory-access pipeline stage between EXE and WB of the LA32R core. It latches one instruction from EXE, issues a data request on a split address/data handshake bus, and aligns and extends load data. It holds the result until WB accepts it and provides forwarding and load-use stall information back to EXE. It replaces the pass-through MEM register with a stage that tolerates variable-latency data memory.

---
 rtl/mem_stage.sv | 103 ++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: LA32R memory stage with split address/data handshake, load alignment,
// result hold for WB and forwarding / load-use stall info for EXE.
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allow_in,
  input  logic [31:0] es_pc,
  input  logic        es_mem_req,
  input  logic        es_mem_wr,
  input  logic [1:0]  es_mem_size,
  input  logic        es_mem_unsigned,
  input  logic [31:0] es_addr,
  input  logic [31:0] es_wdata,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic [31:0] es_alu_result,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic        ms_to_ws_valid,
  input  logic        ws_allow_in,
  output logic [31:0] ms_pc,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_rf_wdata,
  output logic        ms_ale,
  output logic        ms_fwd_valid,
  output logic        ms_fwd_busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic        mem_req, wr, uns, accept, e_ale;
  logic [1:0]  size;
  logic [31:0] addr, result, shifted, ld_data, e_wdata;
  logic [3:0]  e_strb;
  assign ms_allow_in    = state == IDLE || (state == DONE && ws_allow_in);
  assign accept         = es_to_ms_valid && ms_allow_in;
  assign data_req       = state == REQ;
  assign data_wr        = wr;
  assign data_addr      = {addr[31:2], 2'b00};
  assign ms_to_ws_valid = state == DONE;
  assign ms_rf_wdata    = result;
  assign ms_fwd_busy    = (state == REQ || state == WAIT) && mem_req && !wr;
  assign ms_fwd_valid   = state != IDLE && ms_rf_we && |ms_rf_waddr && !ms_fwd_busy;
  always_comb begin
    e_ale   = es_mem_req && ((es_mem_size == 2'd1 && es_addr[0]) || (es_mem_size[1] && |es_addr[1:0]));
    e_strb  = !es_mem_wr ? 4'b0000 :
              es_mem_size == 2'd0 ? 4'b0001 << es_addr[1:0] :
              es_mem_size == 2'd1 ? (es_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    e_wdata = es_mem_size == 2'd0 ? {4{es_wdata[7:0]}} :
              es_mem_size == 2'd1 ? {2{es_wdata[15:0]}} : es_wdata;
    shifted = data_rdata >> {addr[1:0], 3'b000};
    ld_data = size == 2'd0 ? {{24{!uns && shifted[7]}}, shifted[7:0]} :
              size == 2'd1 ? {{16{!uns && shifted[15]}}, shifted[15:0]} : data_rdata;
  end
  // Store strobe/lanes are formed at accept so they stay constant through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ms_pc       <= RESET_PC;
      mem_req     <= 1'b0;
      wr          <= 1'b0;
      uns         <= 1'b0;
      size        <= 2'd0;
      addr        <= 32'd0;
      result      <= 32'd0;
      data_wstrb  <= 4'd0;
      data_wdata  <= 32'd0;
      ms_rf_we    <= 1'b0;
      ms_rf_waddr <= 5'd0;
      ms_ale      <= 1'b0;
    end else if (accept) begin
      state       <= (es_mem_req && !e_ale) ? REQ : DONE;
      ms_pc       <= es_pc;
      mem_req     <= es_mem_req;
      wr          <= es_mem_wr;
      uns         <= es_mem_unsigned;
      size        <= es_mem_size;
      addr        <= es_addr;
      result      <= es_alu_result;
      data_wstrb  <= e_strb;
      data_wdata  <= e_wdata;
      ms_rf_we    <= es_rf_we && !e_ale;
      ms_rf_waddr <= es_rf_waddr;
      ms_ale      <= e_ale;
    end else if (state == DONE && ws_allow_in) begin
      state <= IDLE;
    end else if (state == REQ && data_addr_ok) begin
      state <= WAIT;
    end else if (state == WAIT && data_data_ok) begin
      state  <= DONE;
      result <= wr ? result : ld_data;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and randomized checks of mem_stage against a
// lane/arith reference model, plus reset and back-to-back sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        es_to_ms_valid, ms_allow_in, es_mem_req, es_mem_wr, es_mem_unsigned, es_rf_we;
  logic [1:0]  es_mem_size;
  logic [31:0] es_pc, es_addr, es_wdata, es_alu_result;
  logic [4:0]  es_rf_waddr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        ms_to_ws_valid, ws_allow_in, ms_rf_we, ms_ale, ms_fwd_valid, ms_fwd_busy;
  logic [31:0] ms_pc, ms_rf_wdata;
  logic [4:0]  ms_rf_waddr;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(rst_n), .es_to_ms_valid(es_to_ms_valid), .ms_allow_in(ms_allow_in),
    .es_pc(es_pc), .es_mem_req(es_mem_req), .es_mem_wr(es_mem_wr), .es_mem_size(es_mem_size),
    .es_mem_unsigned(es_mem_unsigned), .es_addr(es_addr), .es_wdata(es_wdata),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_alu_result(es_alu_result),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_ale(ms_ale), .ms_fwd_valid(ms_fwd_valid), .ms_fwd_busy(ms_fwd_busy)
  );

  typedef struct {
    logic        mem_req, wr, uns, rf_we, spur;
    logic [1:0]  size;
    logic [31:0] addr, wdata, alu, rdata, pc;
    logic [4:0]  waddr;
    int          d_a, d_d, hold;
    logic [31:0] exp_rf, exp_wd;
    logic [3:0]  exp_strb;
    logic        exp_ale;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic mem_req, logic wr, logic [1:0] size, logic uns,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] alu,
                              logic [31:0] rdata, logic rf_we, logic [4:0] waddr,
                              int d_a, int d_d, logic spur, int hold, logic [31:0] exp_rf,
                              logic exp_ale, logic [3:0] exp_strb, logic [31:0] exp_wd);
    vec_t v;
    v.mem_req = mem_req; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.alu = alu; v.rdata = rdata; v.rf_we = rf_we; v.waddr = waddr;
    v.d_a = d_a; v.d_d = d_d; v.spur = spur; v.hold = hold; v.exp_rf = exp_rf;
    v.exp_ale = exp_ale; v.exp_strb = exp_strb; v.exp_wd = exp_wd; v.pc = 32'h0;
    return v;
  endfunction

  // Reference: byte-lane view of the access, arithmetic sign extension.
  function automatic vec_t model(vec_t v);
    int nb, off;
    logic [31:0] val;
    nb = v.size == 2'd0 ? 1 : v.size == 2'd1 ? 2 : 4;
    off = int'(v.addr % 4);
    v.exp_ale = v.mem_req && (v.addr % nb != 0);
    v.exp_strb = 4'd0;
    v.exp_wd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) v.exp_strb[i] = 1'b1;
      v.exp_wd[8*i+:8] = v.wdata[8*(i%nb)+:8];
    end
    val = v.rdata >> (8 * off);
    if (nb < 4) begin
      val = val & ((32'd1 << (8 * nb)) - 32'd1);
      if (!v.uns && val[8*nb-1]) val = val - (32'd1 << (8 * nb));
    end
    v.exp_rf = (v.mem_req && !v.wr) ? val : v.alu;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    es_pc = v.pc; es_mem_req = v.mem_req; es_mem_wr = v.wr; es_mem_size = v.size;
    es_mem_unsigned = v.uns; es_addr = v.addr; es_wdata = v.wdata; es_rf_we = v.rf_we;
    es_rf_waddr = v.waddr; es_alu_result = v.alu;
  endtask

  // Called at a negedge with the stage idle.
  task automatic run(input string tag, input vec_t v);
    logic load;
    load = v.mem_req && !v.wr;
    chk({tag, " allow_in idle"}, 32'(ms_allow_in), 32'd1);
    drive(v);
    es_to_ms_valid = 1'b1;
    ws_allow_in = v.hold == 0;
    @(posedge clk); @(negedge clk);
    es_to_ms_valid = 1'b0;
    es_pc = $urandom; es_addr = $urandom; es_wdata = $urandom; es_alu_result = $urandom;
    if (v.mem_req && !v.exp_ale) begin
      for (int i = 0; i <= v.d_a; i++) begin
        chk({tag, " req"}, 32'(data_req), 32'd1);
        chk({tag, " addr"}, data_addr, v.addr & 32'hFFFF_FFFC);
        chk({tag, " wr"}, 32'(data_wr), 32'(v.wr));
        if (v.wr) begin
          chk({tag, " wstrb"}, 32'(data_wstrb), 32'(v.exp_strb));
          chk({tag, " wdata"}, data_wdata, v.exp_wd);
        end
        chk({tag, " busy req"}, 32'(ms_fwd_busy), 32'(load));
        chk({tag, " to_ws req"}, 32'(ms_to_ws_valid), 32'd0);
        data_data_ok = v.spur && i == 0 && v.d_a > 0;
        data_rdata = 32'hBAD0_BAD0;
        data_addr_ok = i == v.d_a;
        @(posedge clk); @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
      end
      for (int j = 0; j <= v.d_d; j++) begin
        chk({tag, " req wait"}, 32'(data_req), 32'd0);
        chk({tag, " busy wait"}, 32'(ms_fwd_busy), 32'(load));
        chk({tag, " to_ws wait"}, 32'(ms_to_ws_valid), 32'd0);
        data_data_ok = j == v.d_d;
        data_rdata = j == v.d_d ? v.rdata : $urandom;
        @(posedge clk); @(negedge clk);
        data_data_ok = 1'b0;
        data_rdata = $urandom;
      end
    end
    for (int h = 0; h <= v.hold; h++) begin
      chk({tag, " to_ws"}, 32'(ms_to_ws_valid), 32'd1);
      chk({tag, " pc"}, ms_pc, v.pc);
      chk({tag, " ale"}, 32'(ms_ale), 32'(v.exp_ale));
      chk({tag, " rf_we"}, 32'(ms_rf_we), 32'(v.rf_we && !v.exp_ale));
      chk({tag, " waddr"}, 32'(ms_rf_waddr), 32'(v.waddr));
      if (!v.exp_ale) chk({tag, " rf_wdata"}, ms_rf_wdata, v.exp_rf);
      chk({tag, " fwd_valid"}, 32'(ms_fwd_valid), 32'(v.rf_we && !v.exp_ale && v.waddr != 0));
      chk({tag, " busy done"}, 32'(ms_fwd_busy), 32'd0);
      chk({tag, " req done"}, 32'(data_req), 32'd0);
      if (h == v.hold) ws_allow_in = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk({tag, " drained"}, 32'(ms_to_ws_valid), 32'd0);
  endtask

  vec_t tbl[10];
  vec_t v, w;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(0,0,2'd2,0, 32'h0,        32'h0,      32'h12345678, 32'h0,       1,5, 0,0,0,0, 32'h12345678, 0, 4'h0, 32'h0);
    tbl[1] = mk(1,0,2'd0,0, 32'h10000003, 32'h0,      32'h10000003, 32'h80FF0000,1,6, 0,0,0,0, 32'hFFFFFF80, 0, 4'h0, 32'h0);
    tbl[2] = mk(1,0,2'd0,1, 32'h10000003, 32'h0,      32'h10000003, 32'h80FF0000,1,6, 0,0,0,1, 32'h00000080, 0, 4'h0, 32'h0);
    tbl[3] = mk(1,0,2'd1,0, 32'h10000002, 32'h0,      32'h10000002, 32'h80FF0000,1,7, 0,0,0,0, 32'hFFFF80FF, 0, 4'h0, 32'h0);
    tbl[4] = mk(1,1,2'd1,0, 32'h10000002, 32'h0000ABCD,32'h10000002,32'h0,       0,0, 2,0,0,0, 32'h10000002, 0, 4'hC, 32'hABCDABCD);
    tbl[5] = mk(1,0,2'd2,0, 32'h10000001, 32'h0,      32'h10000001, 32'h0,       1,8, 0,0,0,1, 32'h0,        1, 4'h0, 32'h0);
    tbl[6] = mk(1,0,2'd2,0, 32'h20000008, 32'h0,      32'h20000008, 32'hDEADBEEF,1,9, 2,5,1,2, 32'hDEADBEEF, 0, 4'h0, 32'h0);
    tbl[7] = mk(1,0,2'd1,1, 32'h20000000, 32'h0,      32'h20000000, 32'h1234F00D,1,10,1,1,1,0, 32'h0000F00D, 0, 4'h0, 32'h0);
    tbl[8] = mk(1,1,2'd0,0, 32'h30000001, 32'h123456A5,32'h30000001,32'h0,       0,0, 0,2,0,0, 32'h30000001, 0, 4'h2, 32'hA5A5A5A5);
    tbl[9] = mk(0,0,2'd0,0, 32'h0,        32'h0,      32'h0BADF00D, 32'h0,       1,0, 0,0,0,0, 32'h0BADF00D, 0, 4'h0, 32'h0);
    rst_n = 1'b0; es_to_ms_valid = 1'b0; ws_allow_in = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    chk("rst allow_in", 32'(ms_allow_in), 32'd1);
    chk("rst req", 32'(data_req), 32'd0);
    chk("rst to_ws", 32'(ms_to_ws_valid), 32'd0);
    chk("rst fwd", {30'd0, ms_fwd_valid, ms_fwd_busy}, 32'd0);
    chk("rst pc", ms_pc, 32'h1c000000);
    chk("rst misc", {ms_ale, ms_rf_we, ms_rf_waddr, data_wstrb, data_wr}, 32'd0);
    chk("rst data", ms_rf_wdata | data_addr | data_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      tbl[k].pc = 32'h1c000100 + 32'(k) * 4;
      run($sformatf("vec%0d", k), tbl[k]);
    end
    // Back-to-back handoff in DONE.
    v = tbl[0]; v.pc = 32'h1c000200;
    w = tbl[9]; w.pc = 32'h1c000204; w.alu = 32'h55667788;
    drive(v); es_to_ms_valid = 1'b1; ws_allow_in = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b2b first pc", ms_pc, v.pc);
    chk("b2b allow_in", 32'(ms_allow_in), 32'd1);
    drive(w);
    @(posedge clk); @(negedge clk);
    es_to_ms_valid = 1'b0;
    chk("b2b second valid", 32'(ms_to_ws_valid), 32'd1);
    chk("b2b second pc", ms_pc, w.pc);
    chk("b2b second data", ms_rf_wdata, 32'h55667788);
    @(posedge clk); @(negedge clk);
    chk("b2b drained", 32'(ms_to_ws_valid), 32'd0);
    // Asynchronous reset while waiting for data.
    v = tbl[1]; v.pc = 32'h1c000300;
    drive(v); es_to_ms_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    es_to_ms_valid = 1'b0; data_addr_ok = 1'b1;
    @(posedge clk); @(negedge clk);
    data_addr_ok = 1'b0;
    chk("wait busy", 32'(ms_fwd_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst allow_in", 32'(ms_allow_in), 32'd1);
    chk("arst busy", 32'(ms_fwd_busy), 32'd0);
    chk("arst pc", ms_pc, 32'h1c000000);
    chk("arst misc", {ms_to_ws_valid, data_req, ms_fwd_valid, ms_ale, ms_rf_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("post_reset", tbl[0]);
    for (int k = 0; k < 40; k++) begin
      v.mem_req = ($urandom % 4) != 0;
      v.wr = $urandom % 2;
      v.size = 2'($urandom % 4);
      v.uns = $urandom % 2;
      v.addr = $urandom;
      if ($urandom % 2) v.addr = v.addr & 32'hFFFF_FFFC;
      v.wdata = $urandom; v.alu = $urandom; v.rdata = $urandom; v.pc = $urandom;
      v.rf_we = v.mem_req ? !v.wr : 1'($urandom % 2);
      v.waddr = 5'($urandom % 32);
      v.d_a = $urandom % 4; v.d_d = $urandom % 4;
      v.spur = $urandom % 2; v.hold = $urandom % 3;
      run($sformatf("rnd%0d", k), model(v));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
